spi_flash_boot_loader: RTL and testbench
========================================

Name: spi_flash_boot_loader

Overview:
Upstream of the RV32E core. After reset, copies a program image from external SPI NOR flash into instruction memory through the ITCM write port, holding the core in reset until the copy completes. Drives the board SPI pins during boot; the core's SPI controller gets the pins once `boot_done` is high (pin muxing lives in the top level). Flash transactions use SPI mode 0, READ command 0x03, single transaction.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period (≥1).
- WORD_COUNT, 1024, 32-bit words copied (1..1024; the ITCM is 4 KiB).
- FLASH_BASE_ADDR, 24'h000000, flash byte address of the image.

Ports:
- clk  in  1  core clock (130 MHz domain).
- rst  in  1  asynchronous active-high reset.
- spi_sck  out  1  flash serial clock.
- spi_mosi  out  1  flash data in.
- spi_miso  in  1  flash data out.
- spi_cs  out  1  flash chip select, active-low.
- itcm_we  out  1  one-cycle ITCM write strobe.
- itcm_addr  out  12  ITCM byte address, word-aligned.
- itcm_wdata  out  32  ITCM write data.
- core_hold  out  1  high = core kept in reset.
- boot_done  out  1  sticky, high after the copy finishes.
- boot_error  out  1  sticky; see Optional Feature.

Behaviour:
- Reset values (asynchronous, immediate on `rst` rise):
  - spi_cs=1, spi_sck=0, spi_mosi=0.
  - itcm_we=0, itcm_addr=0, itcm_wdata=0.
  - core_hold=1, boot_done=0, boot_error=0.
  - All counters 0; state=IDLE.
- Timing and sampling:
  - Bit timer counts 0..CLK_DIV-1; each wrap toggles SCK.
  - One bit = 2*CLK_DIV clk cycles.
  - MOSI changes while SCK=0; MISO is sampled on the SCK rising edge.
  - Shift order is MSB-first.
- State machine:
  - IDLE: one cycle after reset deasserts → CS_SETUP.
  - CS_SETUP: spi_cs=0 for CLK_DIV cycles, SCK low → CMD.
  - CMD: shift 8'h03 → ADDR.
  - ADDR: shift FLASH_BASE_ADDR[23:0] → DATA.
  - DATA: receive 8 bits per byte, 4 bytes per word. Bytes are little-endian: first byte → wdata[7:0], fourth byte → wdata[31:24]. After the 4th byte → WRITE.
  - WRITE: itcm_we=1 for exactly one cycle, with itcm_addr = word_index*4. SCK is held low (no clocks are sent while writing). word_index increments. If word_index==WORD_COUNT-1 → CS_HOLD, else → DATA.
  - CS_HOLD: SCK low; spi_cs returns to 1 after CLK_DIV cycles → DONE (or CHECK when the checksum is enabled).
  - DONE: boot_done=1 and core_hold=0. Terminal until `rst`.
- itcm_addr is 12 bits and wraps naturally. The WORD_COUNT cap prevents a wrap in normal use; the bench checks that `itcm_addr` never exceeds 12'hFFC.
- itcm_wdata holds its last value outside WRITE.
- Reset mid-transfer: all outputs return to reset values at once, spi_cs goes high, and the copy restarts from word 0 on release. A partially written ITCM is simply overwritten.
- core_hold falls in the same cycle boot_done rises. The core sees reset released on the next edge.
- Total latency from `rst` deassert to boot_done:
  - 1 (IDLE) + CLK_DIV (setup) + 64*CLK_DIV*(1+WORD_COUNT) (SPI bits) + WORD_COUNT (WRITE cycles) + CLK_DIV (hold) cycles, ±1.
  - The bench checks this with a ±2 tolerance.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- With the macro defined:
  - A 32-bit additive sum (mod 2^32) accumulates over words 0..WORD_COUNT-2.
  - Word WORD_COUNT-1 is the expected sum; it is still written to the ITCM.
  - A CHECK state (1 cycle) follows CS_HOLD. On mismatch, boot_error=1, boot_done=1 and core_hold stays 1 (the core never runs). On match it behaves as DONE.
- Without the macro: no accumulator and no CHECK state; boot_error is tied to 0.

Test Plan:
- Flash model, image words 0x00000013 ×8, CLK_DIV=2, WORD_COUNT=8:
  - MOSI sequence is 0x03,0x00,0x00,0x00.
  - Exactly 8 itcm_we pulses at addr 0x000..0x01C, each with wdata 0x00000013.
  - boot_done rises at the computed latency ±2.
- Flash bytes 0x78,0x56,0x34,0x12 at word 0 → first write has itcm_wdata=0x12345678 and itcm_addr=0.
- FLASH_BASE_ADDR=24'h012345 → ADDR phase MOSI bits equal 0x012345, MSB-first.
- Reset asserted during word 3 of 8 → spi_cs=1 and core_hold=1 in the same cycle. After release, the first write goes to addr 0 again and 8 writes total follow.
- BOOT_CHECKSUM_EN, words 1,2,3 plus checksum 6 → boot_error=0, core_hold=0. Same image with checksum 7 → boot_error=1, boot_done=1, core_hold=1.
- CLK_DIV=1 → SCK period is 2 clk cycles. MISO sampled on rising edges matches the model byte for byte.

Source files
------------

// File: rtl/spi_flash_boot_loader.sv
// ---------------------------------------------------------------------------
// spi_flash_boot_loader
//
// Purpose:
//   Boot-time copier that sits upstream of the RV32E core. After reset it
//   opens one SPI mode-0 READ (0x03) transaction to the external NOR flash.
//   It streams WORD_COUNT 32-bit words into instruction memory through the
//   ITCM write port. The core is kept in reset until the copy is complete.
//   Once boot_done is high, the top level hands the SPI pins to the core's
//   own SPI controller.
//
// Parameters:
//   CLK_DIV          clk cycles per SCK half-period (>= 1)
//   WORD_COUNT       number of 32-bit words to copy (1..1024)
//   FLASH_BASE_ADDR  flash byte address of the image
//
// Ports:
//   clk         in   core clock
//   rst         in   asynchronous active-high reset
//   spi_sck     out  flash serial clock (idles low)
//   spi_mosi    out  command/address bits to the flash, MSB first
//   spi_miso    in   data bits from the flash, sampled on SCK rising edges
//   spi_cs      out  flash chip select, active low
//   itcm_we     out  one-cycle ITCM write strobe
//   itcm_addr   out  ITCM byte address (word aligned)
//   itcm_wdata  out  ITCM write data (holds its last value between writes)
//   core_hold   out  high while the core must stay in reset
//   boot_done   out  sticky, set once the copy has finished
//   boot_error  out  sticky, set on checksum mismatch (optional feature)
//
// Optional feature (define BOOT_CHECKSUM_EN):
//   The last image word carries the 32-bit additive sum of all the words
//   before it. A one-cycle CHECK state follows the copy. On a mismatch it
//   raises boot_error and leaves core_hold high, so a corrupt image never
//   runs. Without the macro, boot_error is tied low.
// ---------------------------------------------------------------------------
module spi_flash_boot_loader #(
  parameter int          CLK_DIV         = 4,
  parameter int          WORD_COUNT      = 1024,
  parameter logic [23:0] FLASH_BASE_ADDR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs,
  output logic        itcm_we,
  output logic [11:0] itcm_addr,
  output logic [31:0] itcm_wdata,
  output logic        core_hold,
  output logic        boot_done,
  output logic        boot_error
);

  // Timer width covers 0..CLK_DIV-1; a divider of 1 still needs one bit.
  localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]      LAST_WORD = 10'(WORD_COUNT - 1);

  // Command byte followed by the 24-bit start address, sent as one 32-bit stream.
  localparam logic [31:0]     HEADER    = {8'h03, FLASH_BASE_ADDR};

  typedef enum logic [3:0] {
    IDLE,
    CS_SETUP,
    CMD,
    ADDR,
    DATA,
    WRITE,
    CS_HOLD,
    DONE
`ifdef BOOT_CHECKSUM_EN
    ,
    CHECK
`endif
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [30:0]      tx_shift;
  logic [31:0]      rx_shift;
  logic [9:0]       word_idx;
  logic             div_wrap;

`ifdef BOOT_CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  // The bit timer wraps once per SCK half-period. Every SCK toggle and every
  // timed CS phase is keyed off this single strobe.
  always_comb begin
    div_wrap = (div_cnt == DIV_LAST);
  end

  // Bytes arrive first-byte-first and are shifted in MSB-first, so the first
  // byte ends up in [31:24]. The word is little-endian, so the first byte
  // belongs in [7:0], which means the assembled word has to be byte-reversed.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Main boot sequencer. Every output is registered here. SCK toggles only
  // in CMD/ADDR/DATA. A low half-period is followed by a high one, and MOSI
  // is updated only on the falling toggle, so it stays stable while SCK is
  // high. MISO is captured on the rising toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      word_idx   <= '0;
      spi_cs     <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
      itcm_we    <= 1'b0;
      itcm_addr  <= '0;
      itcm_wdata <= '0;
      core_hold  <= 1'b1;
      boot_done  <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      boot_error <= 1'b0;
      checksum   <= '0;
`endif
    end else begin
      itcm_we <= 1'b0;

      case (state)
        // Select the flash and put the first command bit on MOSI, so it is
        // valid well before the first rising SCK edge.
        IDLE: begin
          spi_cs   <= 1'b0;
          spi_mosi <= HEADER[31];
          tx_shift <= HEADER[30:0];
          div_cnt  <= '0;
          bit_cnt  <= '0;
          word_idx <= '0;
          state    <= CS_SETUP;
        end

        // CS-to-first-edge setup time: one half-period with SCK held low.
        CS_SETUP: begin
          if (div_wrap) begin
            div_cnt <= '0;
            state   <= CMD;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        CMD, ADDR, DATA: begin
          if (!div_wrap) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            spi_sck <= ~spi_sck;
            if (!spi_sck) begin
              // Rising toggle: the flash has had a full half-period to settle MISO.
              if (state == DATA) begin
                rx_shift <= {rx_shift[30:0], spi_miso};
              end
            end else begin
              // Falling toggle: the current bit is complete.
              bit_cnt  <= bit_cnt + 5'd1;
              spi_mosi <= tx_shift[30];
              tx_shift <= {tx_shift[29:0], 1'b0};
              if (state == CMD && bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                state   <= ADDR;
              end else if (state == ADDR && bit_cnt == 5'd23) begin
                bit_cnt  <= '0;
                spi_mosi <= 1'b0;
                state    <= DATA;
              end else if (state == DATA && bit_cnt == 5'd31) begin
                bit_cnt    <= '0;
                itcm_we    <= 1'b1;
                itcm_addr  <= {word_idx, 2'b00};
                itcm_wdata <= byte_swap(rx_shift);
                state      <= WRITE;
              end
            end
          end
        end

        // The strobe is already high for this cycle. SCK stays low, so the
        // flash simply waits with the next bit parked on MISO.
        WRITE: begin
          word_idx <= word_idx + 10'd1;
`ifdef BOOT_CHECKSUM_EN
          if (word_idx != LAST_WORD) begin
            checksum <= checksum + itcm_wdata;
          end
`endif
          if (word_idx == LAST_WORD) begin
            state <= CS_HOLD;
          end else begin
            state <= DATA;
          end
        end

        // CS hold time after the final bit, then release the flash.
        CS_HOLD: begin
          if (div_wrap) begin
            div_cnt <= '0;
            spi_cs  <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
            state     <= CHECK;
`else
            boot_done <= 1'b1;
            core_hold <= 1'b0;
            state     <= DONE;
`endif
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

`ifdef BOOT_CHECKSUM_EN
        // itcm_wdata still holds the last word written, which is the stored sum.
        CHECK: begin
          boot_done <= 1'b1;
          if (checksum == itcm_wdata) begin
            core_hold <= 1'b0;
          end else begin
            boot_error <= 1'b1;
          end
          state <= DONE;
        end
`endif

        DONE: begin
          state <= DONE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef BOOT_CHECKSUM_EN
  // Without the checksum there is nothing that can fail.
  assign boot_error = 1'b0;
`endif

endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_spi_flash_boot_loader
//
// Two boot loaders share one clock:
//   instance 0: CLK_DIV=2, base address 0x000000
//   instance 1: CLK_DIV=1, base address 0x012345
//
// Each instance has a behavioural SPI flash that captures the 32-bit
// command/address header. After the header, the flash streams the image
// bytes (little-endian words starting at the base address) on falling SCK
// edges.
//
// A table of boot scenarios is applied in turn. The expected ITCM writes,
// header, latency and checksum outcome are computed from the image with
// plain arithmetic.
// ---------------------------------------------------------------------------
module tb_spi_flash_boot_loader;

  localparam int          WC    = 8;
  localparam int          DIV0  = 2;
  localparam int          DIV1  = 1;
  localparam logic [23:0] BASE0 = 24'h000000;
  localparam logic [23:0] BASE1 = 24'h012345;
`ifdef BOOT_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam int K_FILL  = 0;  // every word 0x00000013
  localparam int K_RAND  = 1;  // random words, word 0 given
  localparam int K_RESET = 2;  // random words, reset during word 3, then rerun
  localparam int K_GOOD  = 3;  // words 1..WC-1 followed by their sum
  localparam int K_BAD   = 4;  // as K_GOOD but with the sum off by one

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        spi_sck    [2];
  logic        spi_mosi   [2];
  logic        spi_cs     [2];
  logic        itcm_we    [2];
  logic [11:0] itcm_addr  [2];
  logic [31:0] itcm_wdata [2];
  logic        core_hold  [2];
  logic        boot_done  [2];
  logic        boot_error [2];
  logic [31:0] hdr_seen   [2];
  logic [31:0] image      [2][WC];

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  function automatic int div_of(input int g);
    return (g == 0) ? DIV0 : DIV1;
  endfunction

  function automatic logic [23:0] base_of(input int g);
    return (g == 0) ? BASE0 : BASE1;
  endfunction

  // Bit k of the data stream that follows the header. Flash bytes outside
  // the image read back as erased (all ones).
  function automatic logic flash_bit(input int g, input logic [23:0] addr, input int k);
    int          off;
    logic [31:0] w;
    logic [7:0]  b;
    off = int'({8'h00, addr}) + k / 8 - int'({8'h00, base_of(g)});
    if (off < 0 || off >= 4 * WC) return 1'b1;
    w = image[g][off / 4];
    b = w[8 * (off % 4) +: 8];
    return b[7 - (k % 8)];
  endfunction

  // One DUT and one flash model per configuration.
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic        miso_l    = 1'b0;
    int          fbits     = 0;
    logic [31:0] fhdr      = '0;
    logic [31:0] fhdr_done = '0;

    spi_flash_boot_loader #(
      .CLK_DIV        ((g == 0) ? DIV0 : DIV1),
      .WORD_COUNT     (WC),
      .FLASH_BASE_ADDR((g == 0) ? BASE0 : BASE1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .spi_sck   (spi_sck[g]),
      .spi_mosi  (spi_mosi[g]),
      .spi_miso  (miso_l),
      .spi_cs    (spi_cs[g]),
      .itcm_we   (itcm_we[g]),
      .itcm_addr (itcm_addr[g]),
      .itcm_wdata(itcm_wdata[g]),
      .core_hold (core_hold[g]),
      .boot_done (boot_done[g]),
      .boot_error(boot_error[g])
    );

    assign hdr_seen[g] = fhdr_done;

    // Mode-0 flash: takes MOSI on rising SCK and restarts whenever CS rises.
    always @(posedge spi_sck[g] or posedge spi_cs[g]) begin
      if (spi_cs[g]) begin
        fbits <= 0;
      end else begin
        if (fbits < 32) fhdr <= {fhdr[30:0], spi_mosi[g]};
        if (fbits == 31) fhdr_done <= {fhdr[30:0], spi_mosi[g]};
        fbits <= fbits + 1;
      end
    end

    // Data is driven on falling SCK, once the header has been received.
    always @(negedge spi_sck[g]) begin
      if (!spi_cs[g] && fbits >= 32) miso_l <= flash_bit(g, fhdr[23:0], fbits - 32);
    end
  end

  // Bus monitor. It logs ITCM writes and counts three kinds of violation:
  // out-of-range addresses, malformed SCK high phases, and MOSI moving while
  // SCK is high.
  logic [11:0] wr_addr_q [2][$];
  logic [31:0] wr_data_q [2][$];
  int   addr_bad  [2] = '{0, 0};
  int   hi_bad    [2] = '{0, 0};
  int   mosi_bad  [2] = '{0, 0};
  int   hi_run    [2] = '{0, 0};
  logic prev_sck  [2] = '{1'b0, 1'b0};
  logic prev_mosi [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst[g] !== 1'b0) begin
        hi_run[g] <= 0;
      end else begin
        if (itcm_we[g] === 1'b1) begin
          wr_addr_q[g].push_back(itcm_addr[g]);
          wr_data_q[g].push_back(itcm_wdata[g]);
          if (itcm_addr[g] > 12'hFFC || itcm_addr[g][1:0] != 2'b00) addr_bad[g] <= addr_bad[g] + 1;
        end
        if (spi_sck[g]) begin
          hi_run[g] <= hi_run[g] + 1;
          if (prev_sck[g] && spi_mosi[g] !== prev_mosi[g]) mosi_bad[g] <= mosi_bad[g] + 1;
        end else if (prev_sck[g]) begin
          if (hi_run[g] != div_of(g)) hi_bad[g] <= hi_bad[g] + 1;
          hi_run[g] <= 0;
        end
      end
      prev_sck[g]  <= spi_sck[g];
      prev_mosi[g] <= spi_mosi[g];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic checkRange(input string name, input int actual, input int expected, input int tol);
    check_cnt++;
    if (actual >= expected - tol && actual <= expected + tol) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d +/- %0d", name, actual, expected, tol);
  endtask

  // Builds the image, resets the chosen instance, runs one complete boot and
  // compares everything against the reference model.
  task automatic applyStimulus(input int g, input int kind, input logic [31:0] word0);
    int          base_idx;
    int          cycles;
    int          nwr;
    int          exp_lat;
    logic [31:0] sum;
    logic [31:0] act;
    logic        exp_err;

    for (int i = 0; i < WC; i++) begin
      case (kind)
        K_FILL:        image[g][i] = 32'h0000_0013;
        K_GOOD, K_BAD: image[g][i] = 32'(i + 1);
        default:       image[g][i] = $urandom();
      endcase
    end
    if (kind == K_RAND || kind == K_RESET) image[g][0] = word0;
    sum = '0;
    for (int i = 0; i < WC - 1; i++) sum += image[g][i];
    if (kind == K_GOOD) image[g][WC-1] = sum;
    if (kind == K_BAD)  image[g][WC-1] = sum + 32'd1;
    exp_err = CHK_EN && (sum != image[g][WC-1]);
    exp_lat = 1 + 2 * div_of(g) + 64 * div_of(g) * (1 + WC) + WC;

    $display("[TB] instance %0d scenario %0d word0=0x%08h", g, kind, image[g][0]);

    @(posedge clk); #2;
    rst[g] = 1'b1;
    #1;
    checkOutput("reset_pins",
                32'({spi_cs[g], spi_sck[g], spi_mosi[g], itcm_we[g], core_hold[g], boot_done[g], boot_error[g]}),
                32'b1000100);
    checkOutput("reset_addr", 32'(itcm_addr[g]), 32'h0);
    checkOutput("reset_wdata", itcm_wdata[g], 32'h0);
    repeat (2) @(posedge clk);
    #2 rst[g] = 1'b0;

    if (kind == K_RESET) begin
      base_idx = wr_addr_q[g].size();
      cycles   = 0;
      while (wr_addr_q[g].size() - base_idx < 3 && cycles < 4000) begin
        @(posedge clk); #1;
        cycles++;
      end
      checkOutput("writes_before_reset", 32'(wr_addr_q[g].size() - base_idx), 32'd3);
      #1 rst[g] = 1'b1;
      #1;
      checkOutput("midreset_pins",
                  32'({spi_cs[g], core_hold[g], itcm_we[g], spi_sck[g], boot_done[g]}),
                  32'b11000);
      repeat (2) @(posedge clk);
      #2 rst[g] = 1'b0;
    end

    base_idx = wr_addr_q[g].size();
    cycles   = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (boot_done[g] !== 1'b1 && cycles < 5000);
    checkRange("latency", cycles, exp_lat, 2);

    checkOutput("cmd_addr", hdr_seen[g], {8'h03, base_of(g)});
    nwr = wr_addr_q[g].size() - base_idx;
    checkOutput("write_count", 32'(nwr), 32'(WC));
    for (int i = 0; i < WC; i++) begin
      act = (i < nwr) ? 32'(wr_addr_q[g][base_idx + i]) : 'x;
      checkOutput($sformatf("write%0d_addr", i), act, 32'(4 * i));
      act = (i < nwr) ? wr_data_q[g][base_idx + i] : 'x;
      checkOutput($sformatf("write%0d_data", i), act, image[g][i]);
    end
    checkOutput("boot_done", 32'(boot_done[g]), 32'd1);
    checkOutput("boot_error", 32'(boot_error[g]), 32'(exp_err));
    checkOutput("core_hold", 32'(core_hold[g]), 32'(exp_err));
    checkOutput("cs_released", 32'({spi_cs[g], spi_sck[g]}), 32'b10);

    // DONE is terminal: nothing else moves.
    repeat (20) @(posedge clk);
    #1;
    checkOutput("no_extra_writes", 32'(wr_addr_q[g].size() - base_idx), 32'(WC));
    checkOutput("done_sticky", 32'({boot_done[g], core_hold[g]}), 32'({1'b1, exp_err}));
    checkOutput("addr_range_violations", 32'(addr_bad[g]), 32'd0);
    checkOutput("sck_high_width_violations", 32'(hi_bad[g]), 32'd0);
    checkOutput("mosi_while_sck_high", 32'(mosi_bad[g]), 32'd0);
  endtask

  typedef struct {
    int          inst;
    int          kind;
    logic [31:0] word0;
  } vec_t;

  vec_t vecs [6];

  initial begin
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    #1;
    rst[0] = 1'b1;
    rst[1] = 1'b1;

    vecs[0] = '{0, K_FILL,  32'h0000_0013};
    vecs[1] = '{0, K_RAND,  32'h1234_5678};
    vecs[2] = '{1, K_RAND,  $urandom()};
    vecs[3] = '{0, K_RESET, $urandom()};
    vecs[4] = '{1, K_GOOD,  32'h0000_0001};
    vecs[5] = '{0, K_BAD,   32'h0000_0001};

    repeat (3) @(posedge clk);
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].inst, vecs[v].kind, vecs[v].word0);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
